instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program sequencer: owns the PC, drives the instruction RAM read port, and
// hands each captured instruction to decode over a valid/ready handshake.
// Supports branch redirect, a reserved halt encoding and a program-length halt.
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PROG_LEN   = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] Out_i,
    output logic                  Enable_i,
    output logic                  RW_ram_i,
    output logic [ADDR_WIDTH-1:0] Address_in_i,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  halted,
    output logic [15:0]           fetch_count
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StValid, StHalt} state_e;

    // One extra bit so PROG_LEN == 2^ADDR_WIDTH is never matched by a wrapped PC.
    localparam logic [ADDR_WIDTH:0] ProgLenExt = (ADDR_WIDTH + 1)'(PROG_LEN);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] instr_out_d;
    logic [ADDR_WIDTH-1:0] instr_pc_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  valid_d;
    logic                  enable_d;
    logic                  halted_d;
    logic [15:0]           count_d;
    logic                  redir_oob;
    logic                  halt_word;

    assign pc_inc    = pc_q + ADDR_WIDTH'(1);
    assign redir_oob = ({1'b0, redirect_addr} >= ProgLenExt);
    assign halt_word = (Out_i[DATA_WIDTH-1 -: 8] == 8'hFF);

    // Next-state, PC and registered-output computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_out_d = instr_out;
        instr_pc_d  = instr_pc;
        valid_d     = instr_valid;
        count_d     = fetch_count;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StReq;
            end
            StReq, StWait: begin
                if (redirect_valid) begin
                    // Abort the in-flight fetch; nothing is issued for it.
                    pc_d    = redirect_addr;
                    state_d = redir_oob ? StHalt : StReq;
                end else if (state_q == StReq) begin
                    state_d = StWait;
                end else if (halt_word) begin
                    state_d = StHalt;
                end else begin
                    instr_out_d = Out_i;
                    instr_pc_d  = pc_q;
                    valid_d     = 1'b1;
                    state_d     = StValid;
                end
            end
            StValid: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_inc;
                    if (fetch_count != 16'hFFFF) count_d = fetch_count + 16'd1;
                end
                if (redirect_valid) begin
                    // Without ready the pending instruction is dropped uncounted.
                    valid_d = 1'b0;
                    pc_d    = redirect_addr;
                    state_d = redir_oob ? StHalt : StReq;
                end else if (instr_ready) begin
                    state_d = ({1'b0, pc_inc} == ProgLenExt) ? StHalt : StReq;
                end
            end
            StHalt: begin
                valid_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        enable_d = (state_d == StReq) || (state_d == StWait);
        halted_d = (state_d == StHalt);
        // Address follows the PC except while idle or halted, where it holds.
        addr_d   = ((state_d == StIdle) || (state_d == StHalt)) ? Address_in_i : pc_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            Enable_i     <= 1'b0;
            RW_ram_i     <= 1'b1;
            Address_in_i <= '0;
            instr_out    <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            fetch_count  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            Enable_i     <= enable_d;
            RW_ram_i     <= 1'b1;
            Address_in_i <= addr_d;
            instr_out    <= instr_out_d;
            instr_pc     <= instr_pc_d;
            instr_valid  <= valid_d;
            halted       <= halted_d;
            fetch_count  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_addr;

    // Instance a: PROG_LEN=4; instance b: PROG_LEN=16. Inputs are shared.
    logic [31:0] out_a, out_b, iout_a, iout_b;
    logic [15:0] addr_a, addr_b, ipc_a, ipc_b, cnt_a, cnt_b;
    logic        en_a, en_b, rw_a, rw_b, val_a, val_b, hlt_a, hlt_b;

    logic [31:0] mem [0:15];

    instr_fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .PROG_LEN(4)) dut_a (
        .Clk(Clk), .Reset(Reset), .start(start), .Out_i(out_a),
        .Enable_i(en_a), .RW_ram_i(rw_a), .Address_in_i(addr_a),
        .instr_out(iout_a), .instr_pc(ipc_a), .instr_valid(val_a),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halted(hlt_a), .fetch_count(cnt_a)
    );

    instr_fetch_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .PROG_LEN(16)) dut_b (
        .Clk(Clk), .Reset(Reset), .start(start), .Out_i(out_b),
        .Enable_i(en_b), .RW_ram_i(rw_b), .Address_in_i(addr_b),
        .instr_out(iout_b), .instr_pc(ipc_b), .instr_valid(val_b),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .halted(hlt_b), .fetch_count(cnt_b)
    );

    // Combinational instruction RAM model (words beyond 15 read as zero).
    always_comb begin
        out_a = (addr_a < 16'd16) ? mem[addr_a[3:0]] : 32'h0;
        out_b = (addr_b < 16'd16) ? mem[addr_b[3:0]] : 32'h0;
    end

    always #5 Clk = ~Clk;

    // Selected instance for checking.
    logic        sel;
    logic [31:0] c_out;
    logic [15:0] c_addr, c_pc, c_cnt;
    logic        c_en, c_rw, c_val, c_hlt;
    assign c_out  = sel ? iout_b : iout_a;
    assign c_addr = sel ? addr_b : addr_a;
    assign c_pc   = sel ? ipc_b  : ipc_a;
    assign c_cnt  = sel ? cnt_b  : cnt_a;
    assign c_en   = sel ? en_b   : en_a;
    assign c_rw   = sel ? rw_b   : rw_a;
    assign c_val  = sel ? val_b  : val_a;
    assign c_hlt  = sel ? hlt_b  : hlt_a;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] max_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        if (c_addr > max_addr) max_addr = c_addr;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!c_val && n < 20) begin
            step();
            n++;
        end
        check(tag, {31'b0, c_val}, 32'd1);
    endtask

    task automatic do_reset();
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        Reset          = 1'b1;
        step();
        step();
        Reset          = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".en"},    {31'b0, c_en},  32'd0);
        check({tag, ".rw"},    {31'b0, c_rw},  32'd1);
        check({tag, ".addr"},  {16'b0, c_addr}, 32'd0);
        check({tag, ".iout"},  c_out,          32'd0);
        check({tag, ".ipc"},   {16'b0, c_pc},  32'd0);
        check({tag, ".valid"}, {31'b0, c_val}, 32'd0);
        check({tag, ".halt"},  {31'b0, c_hlt}, 32'd0);
        check({tag, ".cnt"},   {16'b0, c_cnt}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0100_0008 + i;
        sel         = 1'b0;
        instr_ready = 1'b1;
        Reset       = 1'b1;
        start       = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        #1;
        check_reset_vals("rst_a");

        // Sequential program of 4 words on instance a.
        do_reset();
        max_addr = '0;
        pulse_start();
        check("seq.req_en", {31'b0, c_en}, 32'd1);
        check("seq.req_addr", {16'b0, c_addr}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_valid("seq.valid");
            check("seq.pc", {16'b0, c_pc}, k);
            check("seq.out", c_out, 32'h0100_0008 + k);
            step();
        end
        check("seq.halted", {31'b0, c_hlt}, 32'd1);
        check("seq.count", {16'b0, c_cnt}, 32'd4);
        check("seq.en_off", {31'b0, c_en}, 32'd0);
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        check("seq.halt_sticky", {31'b0, c_hlt}, 32'd1);
        check("seq.max_addr", {16'b0, max_addr}, 32'd3);

        // Reserved halt word at address 2 on instance b.
        sel    = 1'b1;
        mem[2] = 32'hFF00_0000;
        do_reset();
        check_reset_vals("rst_b");
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_valid("hw.valid");
            check("hw.pc", {16'b0, c_pc}, k);
            step();
        end
        step();
        check("hw.wait_novalid", {31'b0, c_val}, 32'd0);
        step();
        check("hw.halted", {31'b0, c_hlt}, 32'd1);
        check("hw.novalid", {31'b0, c_val}, 32'd0);
        check("hw.count", {16'b0, c_cnt}, 32'd2);
        mem[2] = 32'h0100_000A;

        // Backpressure: hold ready low at pc=1.
        do_reset();
        pulse_start();
        wait_valid("bp.v0");
        step();
        instr_ready = 1'b0;
        wait_valid("bp.v1");
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp.pc", {16'b0, c_pc}, 32'd1);
            check("bp.out", c_out, 32'h0100_0009);
            check("bp.en", {31'b0, c_en}, 32'd0);
            check("bp.addr", {16'b0, c_addr}, 32'd1);
        end
        check("bp.cnt_hold", {16'b0, c_cnt}, 32'd1);
        instr_ready = 1'b1;
        step();
        check("bp.accept_valid", {31'b0, c_val}, 32'd0);
        check("bp.accept_cnt", {16'b0, c_cnt}, 32'd2);
        check("bp.next_addr", {16'b0, c_addr}, 32'd2);
        wait_valid("bp.v2");
        check("bp.next_pc", {16'b0, c_pc}, 32'd2);

        // Redirect during WAIT of pc=2.
        do_reset();
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_valid("rw.valid");
            step();
        end
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 16'd9;
        step();
        redirect_valid = 1'b0;
        check("rw.addr", {16'b0, c_addr}, 32'd9);
        check("rw.novalid", {31'b0, c_val}, 32'd0);
        wait_valid("rw.v9");
        check("rw.pc", {16'b0, c_pc}, 32'd9);
        check("rw.out", c_out, 32'h0100_0011);
        check("rw.cnt", {16'b0, c_cnt}, 32'd2);

        // Redirect in VALID together with ready: word 1 counted.
        do_reset();
        pulse_start();
        wait_valid("rva.v0");
        step();
        wait_valid("rva.v1");
        redirect_valid = 1'b1;
        redirect_addr  = 16'd5;
        step();
        redirect_valid = 1'b0;
        check("rva.cnt", {16'b0, c_cnt}, 32'd2);
        check("rva.addr", {16'b0, c_addr}, 32'd5);
        wait_valid("rva.v5");
        check("rva.pc", {16'b0, c_pc}, 32'd5);

        // Redirect in VALID without ready: word 1 dropped.
        do_reset();
        pulse_start();
        wait_valid("rvd.v0");
        step();
        instr_ready = 1'b0;
        wait_valid("rvd.v1");
        redirect_valid = 1'b1;
        redirect_addr  = 16'd5;
        step();
        redirect_valid = 1'b0;
        check("rvd.valid", {31'b0, c_val}, 32'd0);
        check("rvd.cnt", {16'b0, c_cnt}, 32'd1);
        check("rvd.addr", {16'b0, c_addr}, 32'd5);
        instr_ready = 1'b1;
        wait_valid("rvd.v5");
        check("rvd.pc", {16'b0, c_pc}, 32'd5);
        check("rvd.cnt5", {16'b0, c_cnt}, 32'd1);

        // Redirect beyond program length halts directly.
        do_reset();
        pulse_start();
        redirect_valid = 1'b1;
        redirect_addr  = 16'd20;
        step();
        redirect_valid = 1'b0;
        check("oob.halted", {31'b0, c_hlt}, 32'd1);
        check("oob.addr_held", {16'b0, c_addr}, 32'd0);

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_valid("ar.valid");
            step();
        end
        step();
        #2;
        Reset = 1'b1;
        #1;
        check_reset_vals("ar");
        #1;
        Reset = 1'b0;
        step();
        pulse_start();
        check("ar.restart_addr", {16'b0, c_addr}, 32'd0);
        wait_valid("ar.v0");
        check("ar.pc", {16'b0, c_pc}, 32'd0);
        check("ar.out", c_out, 32'h0100_0008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
